// File: rtl/seq_alu_if.sv
// Handshake/operand bundle between the EX-stage control unit and seq_alu.
// master = control unit side, slave = the ALU.
interface seq_alu_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic [3:0]       op;
  logic [WIDTH-1:0] in1;
  logic [WIDTH-1:0] in2;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] out;
  logic [WIDTH-1:0] hi_out;
  logic             zero_flag;
  logic             ovf;
  logic             div_zero;

  modport master (
    output start, op, in1, in2,
    input  busy, done, out, hi_out, zero_flag, ovf, div_zero
  );

  modport slave (
    input  start, op, in1, in2,
    output busy, done, out, hi_out, zero_flag, ovf, div_zero
  );
endinterface

// File: rtl/seq_alu.sv
// Sequential ALU: single-cycle ops 0-7, shift-add MULU and restoring DIVU with HI/LO results.
// Optional signed MUL/DIV (ops 10/11) and signed SLT when SEQ_ALU_SIGNED_EN is defined.
module seq_alu #(
  parameter int WIDTH = 32,
  parameter int SHW   = $clog2(WIDTH)
) (
  input logic      clk,
  input logic      reset,
  seq_alu_if.slave bus
);
  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  localparam logic [3:0] OP_ADD  = 4'd0;
  localparam logic [3:0] OP_SUB  = 4'd1;
  localparam logic [3:0] OP_AND  = 4'd2;
  localparam logic [3:0] OP_OR   = 4'd3;
  localparam logic [3:0] OP_SLL  = 4'd4;
  localparam logic [3:0] OP_SRL  = 4'd5;
  localparam logic [3:0] OP_CMP  = 4'd6;
  localparam logic [3:0] OP_SLT  = 4'd7;
  localparam logic [3:0] OP_MULU = 4'd8;
  localparam logic [3:0] OP_DIVU = 4'd9;
`ifdef SEQ_ALU_SIGNED_EN
  localparam logic [3:0] OP_MUL  = 4'd10;
  localparam logic [3:0] OP_DIV  = 4'd11;

  typedef enum logic [2:0] {S_IDLE, S_MUL, S_DIV, S_DONE, S_FIX} state_t;
`else
  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_DONE} state_t;
`endif

  state_t           r_state;
  logic [CW-1:0]    r_cnt;
  logic [WIDTH-1:0] r_a;     // multiplicand or divisor
  logic [WIDTH-1:0] r_lo;    // multiplier shifting out / quotient shifting in
  logic [WIDTH-1:0] r_hi;    // product high accumulator / partial remainder
  logic [WIDTH-1:0] r_out;
  logic [WIDTH-1:0] r_hi_out;
  logic             r_zero;
  logic             r_ovf;
  logic             r_dz;
  logic             r_busy;
  logic             r_done;
`ifdef SEQ_ALU_SIGNED_EN
  logic             r_sgn;
  logic             r_is_div;
  logic             r_neg_a;   // negate product / quotient
  logic             r_neg_b;   // negate remainder
  logic [WIDTH-1:0] w_mag1;
  logic [WIDTH-1:0] w_mag2;
  logic [2*WIDTH-1:0] w_prod;
  logic             w_min_by_m1;

  assign w_mag1 = bus.in1[WIDTH-1] ? -bus.in1 : bus.in1;
  assign w_mag2 = bus.in2[WIDTH-1] ? -bus.in2 : bus.in2;
  assign w_prod = {r_hi, r_lo};
  assign w_min_by_m1 = (bus.in1 == {1'b1, {(WIDTH-1){1'b0}}}) && (bus.in2 == '1);
`endif

  // Single-cycle result and overflow for ops 0-7 (reserved ops yield zero).
  logic [WIDTH-1:0] w_sum;
  logic [WIDTH-1:0] w_diff;
  logic [WIDTH-1:0] w_res;
  logic             w_ovf;
  logic             w_lt;

  assign w_sum  = bus.in1 + bus.in2;
  assign w_diff = bus.in1 - bus.in2;
`ifdef SEQ_ALU_SIGNED_EN
  assign w_lt = $signed(bus.in1) < $signed(bus.in2);
`else
  assign w_lt = bus.in1 < bus.in2;
`endif

  always_comb begin
    w_res = '0;
    w_ovf = 1'b0;
    case (bus.op)
      OP_ADD: begin
        w_res = w_sum;
        w_ovf = (bus.in1[WIDTH-1] == bus.in2[WIDTH-1]) && (w_sum[WIDTH-1] != bus.in1[WIDTH-1]);
      end
      OP_SUB: begin
        w_res = w_diff;
        w_ovf = (bus.in1[WIDTH-1] != bus.in2[WIDTH-1]) && (w_diff[WIDTH-1] != bus.in1[WIDTH-1]);
      end
      OP_AND:  w_res = bus.in1 & bus.in2;
      OP_OR:   w_res = bus.in1 | bus.in2;
      OP_SLL:  w_res = bus.in1 << bus.in2[SHW-1:0];
      OP_SRL:  w_res = bus.in1 >> bus.in2[SHW-1:0];
      OP_CMP:  w_res = '0;
      OP_SLT:  w_res = {{(WIDTH-1){1'b0}}, w_lt};
      default: w_res = '0;
    endcase
  end

  // One shift-add multiply step: add multiplicand if LSB set, shift {carry,hi,lo} right.
  logic [WIDTH:0]     w_mul_sum;
  logic [2*WIDTH-1:0] w_mul_next;
  assign w_mul_sum  = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_a} : {(WIDTH+1){1'b0}});
  assign w_mul_next = {w_mul_sum, r_lo[WIDTH-1:1]};

  // One restoring divide step; partial remainder stays below the divisor.
  logic [WIDTH:0]   w_div_sh;
  logic             w_div_ge;
  logic [WIDTH:0]   w_div_trial;
  logic [WIDTH-1:0] w_rem_next;
  logic [WIDTH-1:0] w_quo_next;
  assign w_div_sh    = {r_hi, r_lo[WIDTH-1]};
  assign w_div_ge    = w_div_sh >= {1'b0, r_a};
  assign w_div_trial = w_div_sh - {1'b0, r_a};
  assign w_rem_next  = w_div_ge ? w_div_trial[WIDTH-1:0] : w_div_sh[WIDTH-1:0];
  assign w_quo_next  = {r_lo[WIDTH-2:0], w_div_ge};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state  <= S_IDLE;
      r_cnt    <= '0;
      r_a      <= '0;
      r_lo     <= '0;
      r_hi     <= '0;
      r_out    <= '0;
      r_hi_out <= '0;
      r_zero   <= 1'b0;
      r_ovf    <= 1'b0;
      r_dz     <= 1'b0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
`ifdef SEQ_ALU_SIGNED_EN
      r_sgn    <= 1'b0;
      r_is_div <= 1'b0;
      r_neg_a  <= 1'b0;
      r_neg_b  <= 1'b0;
`endif
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (bus.start) begin
            r_zero <= (bus.in1 == bus.in2);
            r_ovf  <= 1'b0;
            r_dz   <= 1'b0;
            r_cnt  <= '0;
            r_hi   <= '0;
`ifdef SEQ_ALU_SIGNED_EN
            r_sgn    <= 1'b0;
            r_is_div <= 1'b0;
            r_neg_a  <= 1'b0;
            r_neg_b  <= 1'b0;
`endif
            if (bus.op == OP_MULU) begin
              r_a     <= bus.in1;
              r_lo    <= bus.in2;
              r_busy  <= 1'b1;
              r_state <= S_MUL;
            end else if (bus.op == OP_DIVU && bus.in2 != '0) begin
              r_a     <= bus.in2;
              r_lo    <= bus.in1;
              r_busy  <= 1'b1;
              r_state <= S_DIV;
`ifdef SEQ_ALU_SIGNED_EN
            end else if (bus.op == OP_MUL) begin
              r_a     <= w_mag1;
              r_lo    <= w_mag2;
              r_sgn   <= 1'b1;
              r_neg_a <= bus.in1[WIDTH-1] ^ bus.in2[WIDTH-1];
              r_busy  <= 1'b1;
              r_state <= S_MUL;
            end else if (bus.op == OP_DIV && bus.in2 != '0) begin
              r_a      <= w_mag2;
              r_lo     <= w_mag1;
              r_sgn    <= 1'b1;
              r_is_div <= 1'b1;
              r_neg_a  <= bus.in1[WIDTH-1] ^ bus.in2[WIDTH-1];
              r_neg_b  <= bus.in1[WIDTH-1];
              r_ovf    <= w_min_by_m1;
              r_busy   <= 1'b1;
              r_state  <= S_DIV;
            end else if (bus.op == OP_DIVU || bus.op == OP_DIV) begin
`else
            end else if (bus.op == OP_DIVU) begin
`endif
              r_out    <= '1;
              r_hi_out <= bus.in1;
              r_dz     <= 1'b1;
              r_done   <= 1'b1;
              r_state  <= S_DONE;
            end else begin
              r_out    <= w_res;
              r_hi_out <= '0;
              r_ovf    <= w_ovf;
              r_done   <= 1'b1;
              r_state  <= S_DONE;
            end
          end
        end
        S_MUL: begin
          {r_hi, r_lo} <= w_mul_next;
          r_cnt        <= r_cnt + 1'b1;
          if (r_cnt == LAST) begin
`ifdef SEQ_ALU_SIGNED_EN
            if (r_sgn) r_state <= S_FIX; else
`endif
            begin
              r_out    <= w_mul_next[WIDTH-1:0];
              r_hi_out <= w_mul_next[2*WIDTH-1:WIDTH];
              r_done   <= 1'b1;
              r_busy   <= 1'b0;
              r_state  <= S_DONE;
            end
          end
        end
        S_DIV: begin
          r_hi  <= w_rem_next;
          r_lo  <= w_quo_next;
          r_cnt <= r_cnt + 1'b1;
          if (r_cnt == LAST) begin
`ifdef SEQ_ALU_SIGNED_EN
            if (r_sgn) r_state <= S_FIX; else
`endif
            begin
              r_out    <= w_quo_next;
              r_hi_out <= w_rem_next;
              r_done   <= 1'b1;
              r_busy   <= 1'b0;
              r_state  <= S_DONE;
            end
          end
        end
`ifdef SEQ_ALU_SIGNED_EN
        // Sign fix-up on the magnitude result costs the extra cycle of signed ops.
        S_FIX: begin
          if (r_is_div) begin
            r_out    <= r_neg_a ? -r_lo : r_lo;
            r_hi_out <= r_neg_b ? -r_hi : r_hi;
          end else begin
            {r_hi_out, r_out} <= r_neg_a ? -w_prod : w_prod;
          end
          r_done  <= 1'b1;
          r_busy  <= 1'b0;
          r_state <= S_DONE;
        end
`endif
        S_DONE: r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.busy      = r_busy;
  assign bus.done      = r_done;
  assign bus.out       = r_out;
  assign bus.hi_out    = r_hi_out;
  assign bus.zero_flag = r_zero;
  assign bus.ovf       = r_ovf;
  assign bus.div_zero  = r_dz;
endmodule

// File: tb/tb_seq_alu.sv
// Scoreboard bench for seq_alu: stimulus pushes model results, a monitor pops them on done.
module tb_seq_alu;
  localparam int W = 32;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   cyc = 0;
  int   total = 0;
  int   bad = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  seq_alu_if #(.WIDTH(W)) bus ();
  seq_alu #(.WIDTH(W)) dut (.clk(clk), .reset(reset), .bus(bus));

  typedef struct {
    logic [W-1:0] out;
    logic [W-1:0] hi;
    bit           zf;
    bit           ovf;
    bit           dz;
    int           lat;
    int           acc;
  } exp_t;

  exp_t sbq[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference model: plain wide arithmetic on the operation definitions.
  function automatic exp_t model(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    exp_t   e;
    longint s;
    logic [63:0] p;
    e.out = '0; e.hi = '0; e.ovf = 0; e.dz = 0; e.lat = 1; e.acc = 0;
    e.zf = (a == b);
    case (op)
      4'd0: begin
        e.out = a + b;
        s = longint'($signed(a)) + longint'($signed(b));
        e.ovf = (s > 64'sd2147483647) || (s < -64'sd2147483648);
      end
      4'd1: begin
        e.out = a - b;
        s = longint'($signed(a)) - longint'($signed(b));
        e.ovf = (s > 64'sd2147483647) || (s < -64'sd2147483648);
      end
      4'd2: e.out = a & b;
      4'd3: e.out = a | b;
      4'd4: e.out = a << (b % W);
      4'd5: e.out = a >> (b % W);
      4'd7: e.out = (a < b) ? 1 : 0;
      4'd8: begin
        p = {32'd0, a} * {32'd0, b};
        e.out = p[31:0]; e.hi = p[63:32]; e.lat = W + 1;
      end
      4'd9: begin
        if (b == 0) begin
          e.out = '1; e.hi = a; e.dz = 1;
        end else begin
          e.out = a / b; e.hi = a % b; e.lat = W + 1;
        end
      end
      default: ;
    endcase
    return e;
  endfunction

  // Monitor: every done must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (!reset && bus.done) begin
      if (sbq.size() == 0) begin
        chk("unexpected_done", 64'd1, 64'd0);
      end else begin
        exp_t e;
        e = sbq.pop_front();
        chk("out", bus.out, e.out);
        chk("hi_out", bus.hi_out, e.hi);
        chk("zero_flag", bus.zero_flag, e.zf);
        chk("ovf", bus.ovf, e.ovf);
        chk("div_zero", bus.div_zero, e.dz);
        chk("latency", cyc - e.acc, e.lat);
      end
    end
  end

  task automatic wait_done(input int lat);
    int n = 0;
    while (!bus.done && n < 100) begin
      chk("busy_during", bus.busy, (lat > 1) ? 1 : 0);
      @(negedge clk);
      n++;
    end
    if (!bus.done) chk("done_timeout", 64'd0, 64'd1);
    else chk("busy_at_done", bus.busy, 64'd0);
  endtask

  task automatic issue(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    exp_t e;
    @(negedge clk);
    bus.start = 1'b1; bus.op = op; bus.in1 = a; bus.in2 = b;
    e = model(op, a, b);
    e.acc = cyc;
    sbq.push_back(e);
    @(negedge clk);
    bus.start = 1'b0; bus.in1 = $urandom; bus.in2 = $urandom;
    wait_done(e.lat);
  endtask

  initial begin
    #2000000;
    $display("FAIL global_timeout: got running want finished");
    $fatal(1, "timeout");
  end

  initial begin
    exp_t e;
    int   n;
    bus.start = 1'b0; bus.op = '0; bus.in1 = '0; bus.in2 = '0;
    repeat (3) @(negedge clk);
    chk("rst_out", bus.out, 0);
    chk("rst_hi", bus.hi_out, 0);
    chk("rst_busy", bus.busy, 0);
    chk("rst_done", bus.done, 0);
    chk("rst_flags", {bus.zero_flag, bus.ovf, bus.div_zero}, 0);
    reset = 1'b0;

    issue(4'd0, 32'd3, 32'd4);

    // MULU 7*9 aborted by reset five cycles in.
    @(negedge clk);
    bus.start = 1'b1; bus.op = 4'd8; bus.in1 = 32'd7; bus.in2 = 32'd9;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (4) @(negedge clk);
    chk("pre_rst_busy", bus.busy, 1);
    reset = 1'b1;
    @(negedge clk);
    chk("abort_busy", bus.busy, 0);
    chk("abort_done", bus.done, 0);
    chk("abort_out", bus.out, 0);
    chk("abort_hi", bus.hi_out, 0);
    reset = 1'b0;
    repeat (40) @(negedge clk);
    chk("abort_no_done_busy", bus.busy, 0);
    issue(4'd0, 32'd5, 32'd2);

    issue(4'd1, 32'h8000_0000, 32'd1);
    issue(4'd6, 32'd22, 32'd22);
    issue(4'd8, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    issue(4'd9, 32'd100, 32'd7);
    issue(4'd9, 32'd5, 32'd0);
    issue(4'd4, 32'd1, 32'h0000_0023);
    issue(4'd7, 32'd5, 32'd2);
    issue(4'd7, 32'd2, 32'd5);
    issue(4'd0, 32'h7FFF_FFFF, 32'd1);
    issue(4'd5, 32'h8000_0000, 32'hFFFF_FFFF);
    issue(4'd12, 32'd9, 32'd9);
`ifndef SEQ_ALU_SIGNED_EN
    issue(4'd10, 32'd6, 32'd7);
    issue(4'd11, 32'd6, 32'd3);
`endif

    // start held high throughout a DIVU: only the first op may execute.
    @(negedge clk);
    bus.start = 1'b1; bus.op = 4'd9; bus.in1 = 32'd17; bus.in2 = 32'd5;
    e = model(4'd9, 32'd17, 32'd5);
    e.acc = cyc;
    sbq.push_back(e);
    n = 0;
    do begin
      @(negedge clk);
      bus.op = 4'($urandom_range(0, 9)); bus.in1 = $urandom; bus.in2 = $urandom;
      n++;
    end while (!bus.done && n < 100);
    if (!bus.done) chk("spam_timeout", 64'd0, 64'd1);
    @(negedge clk);
    bus.start = 1'b0;
    repeat (5) @(negedge clk);
    chk("spam_idle_busy", bus.busy, 0);

    // Randomized mix, biased toward equal operands and small divisors.
    for (int i = 0; i < 60; i++) begin
      logic [3:0]   op;
      logic [W-1:0] a;
      logic [W-1:0] b;
      op = 4'($urandom_range(0, 13));
      if (op >= 4'd10) op = op + 4'd2;
      a = $urandom;
      b = $urandom;
      case ($urandom_range(0, 3))
        0: b = a;
        1: b = 32'($urandom_range(0, 9));
        default: ;
      endcase
      issue(op, a, b);
    end

    repeat (5) @(negedge clk);
    chk("sb_empty", sbq.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/seq_alu.md
Name: seq_alu

Overview:
- Parametrised, clocked successor to the processor's combinational ALU.
- Executes the existing 8 ALU operations with a registered single-cycle result.
- Adds multi-cycle unsigned multiply (shift-add) and unsigned divide (restoring), both producing HI/LO results.
- Sits in the EX stage. The control unit drives start/op and stalls the pipeline while busy is high.

Parameters:
- WIDTH, 32, operand and result width in bits (power of 2, at least 8).
- SHW, $clog2(WIDTH), number of shift-amount bits taken from in2.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-high reset.
- start  input  1  launches op on in1/in2; sampled only in IDLE.
- op  input  4  operation select:
  - 0 ADD, 1 SUB, 2 AND, 3 OR, 4 SLL, 5 SRL, 6 CMP, 7 SLT (unsigned compare)
  - 8 MULU, 9 DIVU; 10–15 reserved
- in1  input  WIDTH  operand A.
- in2  input  WIDTH  operand B.
- busy  output  1  high while a MULU/DIVU is in progress.
- done  output  1  one-cycle pulse when out/hi_out are valid.
- out  output  WIDTH  result / LO (product low half, quotient).
- hi_out  output  WIDTH  HI (product high half, remainder); 0 for ops 0–7.
- zero_flag  output  1  in1==in2, captured at accept.
- ovf  output  1  signed overflow for ADD/SUB; 0 otherwise.
- div_zero  output  1  DIVU issued with in2==0.

Behaviour:
- Reset values: all outputs 0, FSM in IDLE, internal accumulators 0.
- Reset is honoured mid-operation: any MULU/DIVU in progress is aborted and no done is issued.
- FSM states: IDLE, MUL, DIV, DONE.
- Accept: in IDLE with start=1, in1/in2/op are latched and zero_flag is updated at that edge.
- Ops 0–7 (IDLE -> DONE):
  - out, ovf and hi_out (=0) are registered at the accept edge.
  - done=1 in the following cycle, i.e. latency 1.
- Op 6 CMP yields out=0. Only zero_flag is meaningful; it is used by BEQ/BNE.
- Shifts use in2[SHW-1:0] only; upper bits of in2 are ignored.
- ovf rules:
  - ADD: ovf = operand signs equal and result sign differs.
  - SUB: ovf = operand signs differ and result sign differs from in1.
  - Arithmetic wraps modulo 2^WIDTH.
- SLT: out = {WIDTH-1 zeros, in1<in2}, unsigned.
- MULU (IDLE -> MUL):
  - busy=1 from the accept edge. One multiplier bit is processed per cycle for WIDTH cycles, then DONE.
  - {hi_out,out} = in1*in2 as a full 2*WIDTH-bit product.
  - done is asserted WIDTH+1 cycles after accept.
- DIVU (IDLE -> DIV):
  - Restoring division, one quotient bit per cycle, WIDTH cycles, then DONE.
  - out = in1/in2, hi_out = in1%in2. Latency WIDTH+1.
- Divide by zero: skips DIV and goes straight to DONE (latency 1) with out=all ones, hi_out=in1, div_zero=1.
- DONE: done=1 and busy=0 for exactly one cycle, then IDLE. start is ignored in DONE.
- start while busy or in DONE is ignored; there is no queueing.
- Reserved ops 10–15 complete in 1 cycle with out=0 and hi_out=0.
- out/hi_out/flags hold their last values until the next done. They change only on the edge that raises done.
- div_zero and ovf are cleared at every accept.

Optional Feature:
- Macro: SEQ_ALU_SIGNED_EN.
- When defined:
  - op 10 MUL (signed): operands are converted to magnitudes and the sign is applied to the 2*WIDTH product after the loop; latency WIDTH+2.
  - op 11 DIV (signed): quotient truncates toward zero, remainder takes the sign of in1; latency WIDTH+2.
  - op 7 SLT becomes a signed compare.
  - Signed divide of most-negative by -1 gives out=most-negative, hi_out=0, ovf=1.
- When undefined: ops 10/11 behave as reserved and SLT stays unsigned.

Test Plan:
- Reset mid-MULU (in1=7, in2=9, reset asserted 5 cycles in) -> busy=0, done never pulses, out=0, hi_out=0; next ADD 5+2 -> out=7, done 1 cycle after accept.
- SUB in1=32'h80000000, in2=1 -> out=32'h7FFFFFFF, ovf=1; CMP with 22 vs 22 -> zero_flag=1, out=0.
- MULU in1=32'hFFFFFFFF, in2=32'hFFFFFFFF -> done exactly 33 cycles after accept, hi_out=32'hFFFFFFFE, out=32'h00000001, busy high for cycles 1–32.
- DIVU in1=100, in2=7 -> out=14, hi_out=2, latency 33; DIVU in2=0, in1=5 -> latency 1, out=32'hFFFFFFFF, hi_out=5, div_zero=1.
- start pulsed every cycle during DIVU 17/5 -> only the first op executes; result 3 rem 2; the start pulse coinciding with DONE is ignored.
- SLL in1=1, in2=32'h00000023 -> out=8 (shift amount 3); SLT 5 vs 2 -> out=0, SLT 2 vs 5 -> out=1.
